// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit (EX-side ex_valid/is_load/is_store/mem_op/alu_out/store_data in; stall/done/wb_valid/wb_data/exc/bus_err out; dmem_req/we/addr/wstrb/wdata/ack/rdata bus), optional LSU_TIMEOUT_EN ack timeout
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        exc,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  state_t state;
  logic [2:0] op_q;
  logic [1:0] k_q;
  logic ld_q, accept, bad, timeout;
  logic [7:0] rb;
  logic [15:0] rh;
  logic [31:0] ld_ext, wdata_n;
  logic [3:0] wstrb_n;
  assign accept = rst_n && state == IDLE && ex_valid && (is_load || is_store);
  assign stall = accept || state == REQ;
  assign bad = (is_load ? (mem_op == 3'b011 || mem_op[2:1] == 2'b11) : (mem_op[2] || mem_op == 3'b011))
            || (mem_op[1:0] == 2'b01 && alu_out[0])
            || (mem_op[1:0] == 2'b10 && alu_out[1:0] != 2'b00);
  assign wstrb_n = mem_op[1:0] == 2'b00 ? 4'b0001 << alu_out[1:0] : mem_op[1:0] == 2'b01 ? 4'b0011 << alu_out[1:0] : 4'b1111;
  assign wdata_n = mem_op[1:0] == 2'b00 ? {4{store_data[7:0]}} : mem_op[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
  assign rb = dmem_rdata[8*k_q +: 8];
  assign rh = k_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  // op_q[2] set means the unsigned (BU/HU) variant, so it suppresses sign fill
  assign ld_ext = op_q[1:0] == 2'b00 ? {{24{~op_q[2] & rb[7]}}, rb}
                : op_q[1:0] == 2'b01 ? {{16{~op_q[2] & rh[15]}}, rh} : dmem_rdata;
`ifdef LSU_TIMEOUT_EN
  logic [15:0] cnt;
  // counter sits at zero outside REQ, so it is already cleared on REQ entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state == REQ && !dmem_ack) ? cnt + 16'd1 : '0;
  assign timeout = state == REQ && !dmem_ack && cnt == 16'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q <= '0;
      k_q <= '0;
      ld_q <= 1'b0;
      done <= 1'b0;
      wb_valid <= 1'b0;
      wb_data <= '0;
      exc <= 1'b0;
      bus_err <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wstrb <= '0;
      dmem_wdata <= '0;
    end else begin
      done <= 1'b0;
      wb_valid <= 1'b0;
      exc <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q <= mem_op;
          k_q <= alu_out[1:0];
          ld_q <= is_load;
          dmem_addr <= {alu_out[31:2], 2'b00};
          dmem_we <= !is_load;
          dmem_wstrb <= is_load ? 4'b0000 : wstrb_n;
          dmem_wdata <= is_load ? 32'd0 : wdata_n;
          dmem_req <= !bad;
          done <= bad;
          exc <= bad;
          state <= bad ? ERR : REQ;
        end
        REQ: if (dmem_ack) begin
          dmem_req <= 1'b0;
          done <= 1'b1;
          wb_valid <= ld_q;
          if (ld_q) wb_data <= ld_ext;
          state <= DONE;
        end else if (timeout) begin
          dmem_req <= 1'b0;
          done <= 1'b1;
          exc <= 1'b1;
          bus_err <= 1'b1;
          state <= ERR;
        end
        DONE: state <= IDLE;
        ERR: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the EX-stage arithmetic unit; consumes its 32-bit result as the effective address.
- Issues one data-memory transaction per memory instruction over a req/ack handshake and stalls the pipeline while it is in flight.
- Aligns store data into byte lanes, and extracts and sign- or zero-extends load data for writeback.
- Flags misaligned and illegal accesses without touching memory.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles to wait for dmem_ack (used only with LSU_TIMEOUT_EN).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage presents an instruction this cycle
is_load  in  1  instruction is a load
is_store  in  1  instruction is a store
mem_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
alu_out  in  32  effective address from the ALU
store_data  in  32  rs2 value
stall  out  1  freeze IF/ID/EX
done  out  1  one-cycle completion pulse (load, store or exception)
wb_valid  out  1  wb_data is valid (loads only)
wb_data  out  32  extended load result
exc  out  1  one-cycle pulse: misaligned, illegal, or timeout
bus_err  out  1  one-cycle pulse: timeout (0 when feature is off)
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address, {alu_out[31:2],2'b00}
dmem_wstrb  out  4  byte-lane write enables
dmem_wdata  out  32  lane-aligned write data
dmem_ack  in  1  memory accepted/completed request; dmem_rdata valid same cycle
dmem_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; registered address/data/op cleared. Reset mid-transaction drops dmem_req in the same instant, with no completion pulse.
- Accept condition: state==IDLE & ex_valid & (is_load|is_store). is_load has priority if both are high. In IDLE, address and store data are captured only on accept.
- stall = accept | (state==REQ). stall is combinational and low in IDLE without accept, in DONE, and in ERR.
- Check at accept:
  - Illegal: load funct3 in {011,110,111}; store funct3 with bit2=1 or ==011.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Either check failing -> ERR.
  - Otherwise -> REQ.
- REQ state:
  - dmem_req=1; dmem_we/addr/wstrb/wdata are registered and held stable until ack.
  - Sample dmem_ack each cycle. On ack: loads latch extracted data -> DONE; stores -> DONE.
  - Ack in the same cycle req first rises is legal (minimum latency).
- Write lanes, with k = addr[1:0]:
  - SB: wstrb = 0001<<k, wdata = {4{sd[7:0]}}.
  - SH: wstrb = 0011<<k, wdata = {2{sd[15:0]}}.
  - SW: wstrb = 1111, wdata = sd.
- Load extraction: select byte k or halfword addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
- DONE state (1 cycle): done=1; wb_valid=1 only for loads; wb_data holds the value until the next DONE. Next state is IDLE. No accept in DONE; EX re-presents next cycle.
- ERR state (1 cycle): done=1, exc=1, wb_valid=0, dmem_req never asserted. Next state is IDLE.
- Latency: accept at cycle N, ack at cycle N+1+w (w >= 0 wait cycles), done at cycle N+2+w. Error: done at N+1.
- dmem_ack outside REQ is ignored.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - 8-bit-or-wider counter cleared on entry to REQ, incremented each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: drop dmem_req, go to ERR, and assert bus_err together with exc. Load destination is not written.
  - Ack arriving in the same cycle as the limit wins (normal DONE).
- LSU_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; bus_err tied to 0.

Test Plan:
- LB at addr 0x1003, rdata 0x80FF_1234, ack after 2 wait cycles:
  - Required: dmem_addr=0x1000; stall high for 4 cycles (accept + 3 REQ); wb_data=0xFFFF_FF80, wb_valid and done pulse once.
- LHU at 0x2002, rdata 0xBEEF_0000, zero-wait ack:
  - Required: wb_data=0x0000_BEEF; done 2 cycles after accept.
- SH at 0x3002, store_data 0x1234_ABCD:
  - Required: dmem_we=1, wstrb=1100, wdata=0xABCD_ABCD; done=1, wb_valid=0.
- LW at 0x4001:
  - Required: no dmem_req; next cycle exc=1, done=1; stall only in accept cycle.
  - Repeat with load funct3=011: same response.
- rst_n pulled low while in REQ with dmem_req=1:
  - Required: dmem_req, stall, done all 0 immediately; after release, a new SW to 0x10 completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, LW at 0x8 with ack held low:
  - Required: dmem_req falls after 4 REQ cycles; exc=bus_err=1 for one cycle.
  - Repeat with ack at exactly cycle 4: normal DONE, bus_err=0.
